// File: rtl/alu_pipe_param.sv
// Parametrised four-stage register-bank ALU pipeline: capture, execute, writeback, store.
// A single S2->S1 forwarding path lets dependent instructions issue back to back.
module alu_pipe_param #(
    parameter int unsigned DW   = 16,
    parameter int unsigned NREG = 16,
    parameter int unsigned AW   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [$clog2(NREG)-1:0] rs1,
    input  logic [$clog2(NREG)-1:0] rs2,
    input  logic [$clog2(NREG)-1:0] rd,
    input  logic [3:0]              func,
    input  logic [AW-1:0]           addr,
    input  logic                    st,
    output logic [DW-1:0]           zout,
    output logic                    zout_valid,
    output logic                    err,
    input  logic [AW-1:0]           mem_raddr,
    output logic [DW-1:0]           mem_rdata
);

    localparam int unsigned RW    = $clog2(NREG);
    localparam int unsigned Depth = 2 ** AW;

    typedef enum logic [3:0] {
        OpAdd  = 4'd0,
        OpSub  = 4'd1,
        OpMul  = 4'd2,
        OpPasa = 4'd3,
        OpPasb = 4'd4,
        OpAnd  = 4'd5,
        OpOr   = 4'd6,
        OpXor  = 4'd7,
        OpNega = 4'd8,
        OpNegb = 4'd9,
        OpSrl  = 4'd10,
        OpSll  = 4'd11,
        OpSra  = 4'd12,
        OpSla  = 4'd13,
        OpLdi  = 4'd14,
        OpIll  = 4'd15
    } op_e;

    logic [DW-1:0] regbank [NREG];
    logic [DW-1:0] mem     [Depth];

    // S1: captured instruction
    logic          s1_valid;
    logic [RW-1:0] s1_rs1;
    logic [RW-1:0] s1_rs2;
    logic [RW-1:0] s1_rd;
    op_e           s1_func;
    logic [AW-1:0] s1_addr;
    logic          s1_st;

    // S2: executed result
    logic          s2_valid;
    logic [RW-1:0] s2_rd;
    logic [DW-1:0] s2_res;
    logic [AW-1:0] s2_addr;
    logic          s2_st;

    // S3: pending store, data is held in zout
    logic          s3_store;
    logic [AW-1:0] s3_addr;

    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic [DW-1:0] alu_res;
    logic          alu_legal;

    // S2 holds the instruction whose regbank write lands on this same edge, so it wins.
    always_comb begin
        op_a = regbank[s1_rs1];
        op_b = regbank[s1_rs2];
        if (s2_valid && (s2_rd == s1_rs1)) begin
            op_a = s2_res;
        end
        if (s2_valid && (s2_rd == s1_rs2)) begin
            op_b = s2_res;
        end
    end

    always_comb begin
        alu_res   = '0;
        alu_legal = 1'b1;
        unique case (s1_func)
            OpAdd:  alu_res = op_a + op_b;
            OpSub:  alu_res = op_a - op_b;
            OpMul:  alu_res = op_a * op_b;
            OpPasa: alu_res = op_a;
            OpPasb: alu_res = op_b;
            OpAnd:  alu_res = op_a & op_b;
            OpOr:   alu_res = op_a | op_b;
            OpXor:  alu_res = op_a ^ op_b;
            OpNega: alu_res = -op_a;
            OpNegb: alu_res = -op_b;
            OpSrl:  alu_res = op_a >> 1;
            OpSll:  alu_res = op_a << 1;
            OpSra:  alu_res = $unsigned($signed(op_a) >>> 1);
            OpSla:  alu_res = op_a << 1;
            OpLdi:  alu_res = DW'(s1_addr);
            OpIll:  alu_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_rs1     <= '0;
            s1_rs2     <= '0;
            s1_rd      <= '0;
            s1_func    <= OpAdd;
            s1_addr    <= '0;
            s1_st      <= 1'b0;
            s2_valid   <= 1'b0;
            s2_rd      <= '0;
            s2_res     <= '0;
            s2_addr    <= '0;
            s2_st      <= 1'b0;
            s3_store   <= 1'b0;
            s3_addr    <= '0;
            zout       <= '0;
            zout_valid <= 1'b0;
            err        <= 1'b0;
        end else begin
            s1_valid   <= in_valid;
            s1_rs1     <= rs1;
            s1_rs2     <= rs2;
            s1_rd      <= rd;
            s1_func    <= op_e'(func);
            s1_addr    <= addr;
            s1_st      <= st;

            s2_valid   <= s1_valid && alu_legal;
            s2_rd      <= s1_rd;
            s2_res     <= alu_res;
            s2_addr    <= s1_addr;
            s2_st      <= s1_st;
            err        <= s1_valid && !alu_legal;

            s3_store   <= s2_valid && s2_st;
            s3_addr    <= s2_addr;
            zout_valid <= s2_valid;
            if (s2_valid) begin
                zout <= s2_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                regbank[i] <= '0;
            end
        end else if (s2_valid) begin
            regbank[s2_rd] <= s2_res;
        end
    end

    // Contents survive reset; only the write is suppressed on a reset edge.
    always_ff @(posedge clk) begin
        if (!rst && s3_store) begin
            mem[s3_addr] <= zout;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rdata <= '0;
        end else begin
            mem_rdata <= mem[mem_raddr];
        end
    end

endmodule

// File: doc/alu_pipe_param.md
Name: alu_pipe_param

Overview:
- Parametrised, single-clock successor of the two-phase register-bank ALU pipeline: operand read, execute, register writeback, memory store.
- Adds generic data width, register count and memory depth, per-instruction valid and store-enable, a load-immediate op and arithmetic shifts.
- Adds a single-path result forwarder so back-to-back dependent instructions need no stalls, illegal-op error reporting, and a registered memory read port.
- Sits between an instruction source and the data memory.

Parameters:
DW, 16, data/register/memory word width
NREG, 16, number of registers; RW = $clog2(NREG) is the register index width
AW, 8, memory address width; depth = 2**AW

Ports:
clk  input  1  single system clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
in_valid  input  1  instruction present this cycle; no backpressure, accepted every cycle
rs1  input  RW  source register A index
rs2  input  RW  source register B index
rd  input  RW  destination register index
func  input  4  operation code
addr  input  AW  store address; also the immediate for LDI
st  input  1  1 = store the result to mem[addr]
zout  output  DW  S3 result register
zout_valid  output  1  zout holds a legal, valid result
err  output  1  one-cycle pulse: illegal func executed
mem_raddr  input  AW  debug/consumer read address
mem_rdata  output  DW  registered read data, 1-cycle latency

Behaviour:
- Stage map:
  - S1: capture the instruction at edge t.
  - S2: execute at edge t+1.
  - S3: at edge t+2, regbank[rd] is written, zout is loaded and zout_valid is raised.
  - S4: at edge t+3, mem[addr] is written when st=1.
- Latency issue to zout is 2 cycles; throughput is 1 instruction per cycle.
- Operand select at S2, per operand:
  - If the S2 register is valid, legal and its rd equals the operand's rs, use the S2 result (forwarding).
  - Otherwise read regbank.
  - Instructions issued 2 or more cycles earlier are already in regbank; no other bypass is needed.
- func table, A/B = operands, all results truncated to DW:
  - 0 ADD A+B; 1 SUB A-B; 2 MUL low DW bits of A*B.
  - 3 PASSA; 4 PASSB; 5 AND; 6 OR; 7 XOR.
  - 8 NEGA two's complement; 9 NEGB.
  - 10 SRL A>>1; 11 SLL A<<1; 12 SRA A>>>1 (sign bit kept); 13 SLA A<<1.
  - 14 LDI zero-extended addr; if AW>DW, take the low DW bits.
  - 15 illegal.
- Illegal op (func 15):
  - err=1 for the cycle following the S2 edge.
  - Valid is dropped: no regbank write, no forwarding, zout_valid=0, no memory store.
  - zout holds its previous value.
- in_valid=0 issues a bubble: it propagates with valid=0 and causes no writes. zout holds, zout_valid=0.
- Write port conflicts:
  - Only the S3 edge writes regbank, so there is one write per cycle.
  - A regbank read and write to the same index on the same edge are resolved by the forwarder; the new value wins.
- Memory:
  - One write port (S4) and one registered read port.
  - A read and write to the same address on the same edge: mem_rdata returns the old data.
  - Address wrap is natural modulo 2**AW.
- Reset, synchronous, edge with rst=1:
  - All stage valid bits, zout_valid and err are set to 0; zout=0, mem_rdata=0; all regbank entries are set to 0.
  - Instructions in flight are discarded and no memory write occurs after the reset edge.
  - Memory contents are not reset.
  - An instruction presented while rst=1 is ignored.

Test Plan:
1. Load and ADD: LDI r3=3, r5=5 spaced 2 cycles apart, then ADD rd=10 rs1=3 rs2=5 st=1 addr=125.
   -> zout=8 with zout_valid 2 cycles after issue; mem[125]=8, read back via mem_raddr=125 giving mem_rdata=8 one cycle later.
2. Forwarding: with r8=8, r6=6, r4=4, issue MUL rd=11 (8*6) then SUB rd=12 rs1=11 rs2=4 on the very next cycle.
   -> zout sequence 48, 44 on consecutive cycles; r12=44.
3. Shift and width: LDI r1=0x80, SLL/SLA to r2 (0x100), then SUB r0=r0-r2 giving 0xFF00, then SRA r7=r0>>>1.
   -> 0xFF80; SRL of 0xFF00 -> 0x7F80; MUL 0xFF00*0x0100 -> 0x0000.
4. Illegal and bubble: func=15 rd=9 st=1 addr=50, followed by in_valid=0.
   -> err high exactly 1 cycle; r9 unchanged; mem[50] unchanged; zout_valid 0 both cycles.
5. Reset mid-flight: issue ADD st=1 addr=200, assert rst on the next edge.
   -> mem[200] unchanged; zout=0, zout_valid=0; every register reads 0 afterward.
6. Memory collision: a store to addr 60 lands on the same edge as mem_raddr=60.
   -> mem_rdata shows the old value, then the new value on the following cycle.
